// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP              = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_KILL = 2'd1,
        S_HOLD = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_t;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer parking a fetched instruction while ID is stalled.
module if_hold_buf
    import if_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   drain,
    input  logic   clear,
    input  fetch_t load_entry,
    output fetch_t entry,
    output logic   full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry.pc   <= '0;
            entry.inst <= NOP;
            full       <= 1'b0;
        end else if (load) begin
            entry <= load_entry;
            full  <= 1'b1;
        end else if (drain || clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID register, imem req/ack handshake and hold buffer.
// Optional stall/wait cycle counter enabled by defining IF_STALL_CNT_EN.
module if_stage
    import if_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            stall,
    input  logic            flush,
    input  logic            Branch,
    input  logic [XLEN-1:0] BranchAddr,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o
`ifdef IF_STALL_CNT_EN
    ,
    output logic [XLEN-1:0] stall_cnt
`endif
);

    if_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic [XLEN-1:0] pc_o_d, inst_o_d;
    logic            valid_o_d;
    logic            buf_load, buf_drain, buf_clear, buf_full;
    fetch_t          buf_entry;
    logic            redirect, squash;
    logic [XLEN-1:0] branch_tgt, pc_inc;
    logic [1:0]      unused_baddr;

    assign redirect     = Branch & ~stall;
    assign squash       = (flush | Branch) & ~stall;
    assign branch_tgt   = {BranchAddr[XLEN-1:2], 2'b00};
    assign unused_baddr = BranchAddr[1:0];
    assign pc_inc       = pc_q + XLEN'(4);

    assign imem_req  = ~rst & (state_q != S_HOLD);
    assign imem_addr = pc_q;

    if_hold_buf u_hold_buf (
        .clk        (clk),
        .rst        (rst),
        .load       (buf_load),
        .drain      (buf_drain),
        .clear      (buf_clear),
        .load_entry ('{pc: pc_q, inst: imem_rdata}),
        .entry      (buf_entry),
        .full       (buf_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            tgt_q   <= RESET_PC;
            pc_o    <= '0;
            inst_o  <= NOP;
            valid_o <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            pc_o    <= pc_o_d;
            inst_o  <= inst_o_d;
            valid_o <= valid_o_d;
        end
    end

    // Next state; IF/ID defaults to a bubble whenever ID is not stalled.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        tgt_d     = tgt_q;
        pc_o_d    = pc_o;
        inst_o_d  = inst_o;
        valid_o_d = valid_o;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        buf_clear = 1'b0;
        if (!stall) begin
            pc_o_d    = '0;
            inst_o_d  = NOP;
            valid_o_d = 1'b0;
        end
        case (state_q)
            S_REQ: begin
                if (imem_ack) begin
                    if (redirect) begin
                        pc_d = branch_tgt;
                    end else begin
                        pc_d = pc_inc;
                        if (stall) begin
                            buf_load = 1'b1;
                            state_d  = S_HOLD;
                        end else if (!flush) begin
                            pc_o_d    = pc_q;
                            inst_o_d  = imem_rdata;
                            valid_o_d = 1'b1;
                        end
                    end
                end else if (redirect) begin
                    tgt_d   = branch_tgt;
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                // Old address stays on the bus until memory answers; the data is dropped.
                if (redirect) tgt_d = branch_tgt;
                if (imem_ack) begin
                    pc_d    = redirect ? branch_tgt : tgt_q;
                    state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    state_d = S_REQ;
                    if (redirect) pc_d = branch_tgt;
                    if (squash) begin
                        buf_clear = 1'b1;
                    end else begin
                        buf_drain = 1'b1;
                        pc_o_d    = buf_entry.pc;
                        inst_o_d  = buf_entry.inst;
                        valid_o_d = buf_full;
                    end
                end
            end
            default: state_d = S_REQ;
        endcase
    end

`ifdef IF_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall || (state_q != S_HOLD && imem_req && !imem_ack)) begin
            stall_cnt <= stall_cnt + XLEN'(1);
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven bench for if_stage with a variable-latency instruction memory.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall, flush, Branch;
    logic [31:0] BranchAddr;
    logic [31:0] pc_o, inst_o;
    logic        valid_o;
`ifdef IF_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    int unsigned lat;
    int unsigned wait_cnt;
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    always #5 clk = ~clk;

    if_stage dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .flush      (flush),
        .Branch     (Branch),
        .BranchAddr (BranchAddr),
        .pc_o       (pc_o),
        .inst_o     (inst_o),
        .valid_o    (valid_o)
`ifdef IF_STALL_CNT_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    // Memory returns the address as data after `lat` wait cycles.
    assign imem_ack   = imem_req && (wait_cnt >= lat);
    assign imem_rdata = imem_addr;

    always @(posedge clk or posedge rst) begin
        if (rst)                       wait_cnt <= 0;
        else if (!imem_req || imem_ack) wait_cnt <= 0;
        else                           wait_cnt <= wait_cnt + 1;
    end

    typedef struct packed {
        logic        stall;
        logic        flush;
        logic        branch;
        logic [31:0] baddr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic [31:0] exp_addr;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic f, input logic b, input logic [31:0] ba,
                                input logic v, input logic [31:0] p, input logic [31:0] i,
                                input logic [31:0] a);
        vec_t r;
        r.stall = s; r.flush = f; r.branch = b; r.baddr = ba;
        r.exp_valid = v; r.exp_pc = p; r.exp_inst = i; r.exp_addr = a;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic f, input logic b, input logic [31:0] ba);
        stall = s; flush = f; Branch = b; BranchAddr = ba;
    endtask

    initial begin
        int found;
        int stale;

        //            stall flush br  baddr         valid pc            inst          next addr
        vecs[0]  = mk(0, 0, 0, 32'h0,         1, 32'h0,         32'h0,         32'h4);
        vecs[1]  = mk(0, 0, 0, 32'h0,         1, 32'h4,         32'h4,         32'h8);
        vecs[2]  = mk(1, 0, 0, 32'h0,         1, 32'h4,         32'h4,         32'hC);
        vecs[3]  = mk(1, 0, 0, 32'h0,         1, 32'h4,         32'h4,         32'hC);
        vecs[4]  = mk(1, 0, 0, 32'h0,         1, 32'h4,         32'h4,         32'hC);
        vecs[5]  = mk(0, 0, 0, 32'h0,         1, 32'h8,         32'h8,         32'hC);
        vecs[6]  = mk(0, 0, 1, 32'h40,        0, 32'h0,         NOP_W,         32'h40);
        vecs[7]  = mk(0, 0, 0, 32'h0,         1, 32'h40,        32'h40,        32'h44);
        vecs[8]  = mk(1, 0, 1, 32'h100,       1, 32'h40,        32'h40,        32'h48);
        vecs[9]  = mk(0, 0, 0, 32'h0,         1, 32'h44,        32'h44,        32'h48);
        vecs[10] = mk(0, 1, 0, 32'h0,         0, 32'h0,         NOP_W,         32'h4C);
        vecs[11] = mk(0, 0, 0, 32'h0,         1, 32'h4C,        32'h4C,        32'h50);
        vecs[12] = mk(0, 0, 1, 32'h7,         0, 32'h0,         NOP_W,         32'h4);
        vecs[13] = mk(0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0,         NOP_W,         32'hFFFF_FFFC);
        vecs[14] = mk(0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0);
        vecs[15] = mk(0, 0, 0, 32'h0,         1, 32'h0,         32'h0,         32'h4);
        vecs[16] = mk(1, 1, 0, 32'h0,         1, 32'h0,         32'h0,         32'h8);
        vecs[17] = mk(0, 1, 0, 32'h0,         0, 32'h0,         NOP_W,         32'h8);
        vecs[18] = mk(0, 0, 0, 32'h0,         1, 32'h8,         32'h8,         32'hC);
        vecs[19] = mk(1, 0, 0, 32'h0,         1, 32'h8,         32'h8,         32'h10);
        vecs[20] = mk(0, 0, 1, 32'h200,       0, 32'h0,         NOP_W,         32'h200);
        vecs[21] = mk(0, 0, 0, 32'h0,         1, 32'h200,       32'h200,       32'h204);

        lat = 0;
        rst = 1'b1;
        drive(0, 0, 0, 32'h0);
        step();
        step();
        check("rst_pc_o",     pc_o,             32'h0);
        check("rst_inst_o",   inst_o,           NOP_W);
        check("rst_valid_o",  32'(valid_o),     32'h0);
        check("rst_imem_req", 32'(imem_req),    32'h0);
        check("rst_addr",     imem_addr,        32'h0);
`ifdef IF_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt,       32'h0);
`endif
        rst = 1'b0;
        #1;
        check("first_req",    32'(imem_req),    32'h1);

        for (int k = 0; k < NVEC; k++) begin
            drive(vecs[k].stall, vecs[k].flush, vecs[k].branch, vecs[k].baddr);
            step();
            check($sformatf("v%0d_valid", k), 32'(valid_o), 32'(vecs[k].exp_valid));
            check($sformatf("v%0d_pc", k),    pc_o,         vecs[k].exp_pc);
            check($sformatf("v%0d_inst", k),  inst_o,       vecs[k].exp_inst);
            check($sformatf("v%0d_addr", k),  imem_addr,    vecs[k].exp_addr);
        end
        drive(0, 0, 0, 32'h0);
`ifdef IF_STALL_CNT_EN
        check("stall_cnt_table", stall_cnt, 32'd6);
`endif

        // Redirect while a slow fetch is outstanding: old data must be dropped.
        drive(0, 0, 1, 32'h10);
        step();
        check("kill_setup_addr", imem_addr, 32'h10);
        lat = 3;
        drive(0, 0, 0, 32'h0);
        step();
        check("kill_wait_addr",  imem_addr, 32'h10);
        check("kill_wait_valid", 32'(valid_o), 32'h0);
        drive(0, 0, 1, 32'h80);
        step();
        drive(0, 0, 0, 32'h0);
        check("kill_addr_held",  imem_addr, 32'h10);
        check("kill_req",        32'(imem_req), 32'h1);
        step();
        check("kill_addr_held2", imem_addr, 32'h10);
        check("kill_ack_now",    32'(imem_ack), 32'h1);
        step();
        check("kill_new_addr",   imem_addr, 32'h80);
        found = 0;
        stale = 0;
        for (int t = 0; t < 10 && found == 0; t++) begin
            step();
            if (valid_o && inst_o == 32'h10) stale++;
            if (valid_o) found = 1;
        end
        check("kill_found",  32'(found), 32'h1);
        check("kill_stale",  32'(stale), 32'h0);
        check("kill_pc_o",   pc_o,       32'h80);
        check("kill_inst_o", inst_o,     32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
